// File: rtl/fighter_anim_ctrl.sv
// Purpose: per-fighter pose sequencer feeding the sprite ROM/palette mux and the attack hitbox flag.
// Latency: state, frame_cnt and facing_move update on the Clk edge where frame_tick=1; decodes follow combinationally.
// Backpressure: none; requests are level-sampled on frame ticks only and ignored while busy or cooling down.
module fighter_anim_ctrl #(
    parameter int PUNCH_FRAMES = 6,
    parameter int KICK_FRAMES  = 8,
    parameter int JUMP_FRAMES  = 16,
    parameter int HIT_START    = 2,
    parameter int HIT_END      = 3,
    parameter int COOLDOWN     = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       req_left,
    input  logic       req_right,
    input  logic       req_up,
    input  logic       req_down,
    input  logic       req_punch,
    input  logic       req_kick,
    input  logic       req_block,
    input  logic       health_zero,
    output logic [3:0] pose_sel,
    output logic [7:0] frame_cnt,
    output logic       attack_active,
    output logic       busy,
    output logic [1:0] facing_move
);

    // Encodings double as the pose select seen by the sprite renderer.
    typedef enum logic [3:0] {
        ST_STAND  = 4'd0,
        ST_MOVE   = 4'd1,
        ST_JUMP   = 4'd2,
        ST_CROUCH = 4'd3,
        ST_PUNCH  = 4'd4,
        ST_KICK   = 4'd5,
        ST_CPUNCH = 4'd6,
        ST_BLOCK  = 4'd7,
        ST_DEAD   = 4'd8
    } state_t;

    localparam logic [7:0] PUNCH_LAST = 8'(PUNCH_FRAMES - 1);
    localparam logic [7:0] KICK_LAST  = 8'(KICK_FRAMES - 1);
    localparam logic [7:0] JUMP_LAST  = 8'(JUMP_FRAMES - 1);
    localparam logic [7:0] HIT_LO     = 8'(HIT_START);
    localparam logic [7:0] HIT_HI     = 8'(HIT_END);
    localparam logic [7:0] CD_LOAD    = 8'(COOLDOWN);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cooldown;
    logic       in_attack;
    logic       leaving_attack;
    logic       punch_go;
    logic       kick_go;

    assign in_attack      = (state == ST_PUNCH) || (state == ST_KICK) || (state == ST_CPUNCH);
    assign leaving_attack = in_attack && (state_nxt != state);

    // Punch outranks kick; a kick is only possible while standing up.
    assign punch_go = (cooldown == 8'd0) && req_punch;
    assign kick_go  = (cooldown == 8'd0) && req_kick && !req_punch && !req_down;

    // State register: moves only on frame ticks.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_STAND;
        end else if (frame_tick) begin
            state <= state_nxt;
        end
    end

    // Per-pose frame counter, attack cooldown and move direction latch.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_cnt   <= 8'd0;
            cooldown    <= 8'd0;
            facing_move <= 2'b00;
        end else if (frame_tick) begin
            if (state_nxt != state) begin
                frame_cnt <= 8'd0;
            end else if (frame_cnt != 8'hFF) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (leaving_attack) begin
                cooldown <= CD_LOAD;
            end else if (cooldown != 8'd0) begin
                cooldown <= cooldown - 8'd1;
            end

            // Direction is captured on entry only and held while the move pose lasts.
            if (state_nxt != ST_MOVE) begin
                facing_move <= 2'b00;
            end else if (state != ST_MOVE) begin
                facing_move <= {req_left, req_right};
            end
        end
    end

    // Next-state: KO wins everywhere, timed poses run out, free poses follow request priority.
    always_comb begin
        state_nxt = state;
        if (health_zero) begin
            state_nxt = ST_DEAD;
        end else begin
            case (state)
                ST_DEAD: begin
                    state_nxt = ST_DEAD;
                end
                ST_JUMP: begin
                    if (frame_cnt == JUMP_LAST) state_nxt = ST_STAND;
                end
                ST_PUNCH: begin
                    if (frame_cnt == PUNCH_LAST) state_nxt = ST_STAND;
                end
                ST_KICK: begin
                    if (frame_cnt == KICK_LAST) state_nxt = ST_STAND;
                end
                ST_CPUNCH: begin
                    if (frame_cnt == PUNCH_LAST) state_nxt = req_down ? ST_CROUCH : ST_STAND;
                end
                default: begin
                    if (punch_go) begin
                        state_nxt = req_down ? ST_CPUNCH : ST_PUNCH;
                    end else if (kick_go) begin
                        state_nxt = ST_KICK;
                    end else if (req_up) begin
                        state_nxt = ST_JUMP;
                    end else if (req_block) begin
                        state_nxt = ST_BLOCK;
                    end else if (req_down) begin
                        state_nxt = ST_CROUCH;
                    end else if (req_left ^ req_right) begin
                        state_nxt = ST_MOVE;
                    end else begin
                        state_nxt = ST_STAND;
                    end
                end
            endcase
        end
    end

    // Output decode from the registered state and frame counter.
    always_comb begin
        pose_sel      = state;
        attack_active = in_attack && (frame_cnt >= HIT_LO) && (frame_cnt <= HIT_HI);
        busy          = in_attack || (state == ST_JUMP);
    end

endmodule
